// File: rtl/ddr3_line_arbiter_if.sv
// ddr3_line_arbiter_if
// Bundles both line requester ports, the DDR3 controller side and the
// arbiter status outputs into one connection.
// slave  : the arbiter (consumes requests, drives the controller side)
// master : the surrounding system (requesters plus DDR3 controller wrapper)
interface ddr3_line_arbiter_if #(
   parameter int LINES_W    = 128,
   parameter int EXT_ADDR_W = 26
);

   logic                  rq0_read_rq;
   logic                  rq0_write_rq;
   logic [EXT_ADDR_W-1:0] rq0_address;
   logic [LINES_W-1:0]    rq0_write_data;
   logic [LINES_W-1:0]    rq0_read_data;
   logic                  rq0_finished;

   logic                  rq1_read_rq;
   logic                  rq1_write_rq;
   logic [EXT_ADDR_W-1:0] rq1_address;
   logic [LINES_W-1:0]    rq1_write_data;
   logic [LINES_W-1:0]    rq1_read_data;
   logic                  rq1_finished;

   logic                  ext_read_rq;
   logic                  ext_write_rq;
   logic                  ext_rq_finished;
   logic [EXT_ADDR_W-1:0] ext_address;
   logic [LINES_W-1:0]    ext_write_data;
   logic [LINES_W-1:0]    ext_read_data;

   logic [1:0]            grant;
   logic                  busy;

   modport slave (
      input  rq0_read_rq, rq0_write_rq, rq0_address, rq0_write_data,
      output rq0_read_data, rq0_finished,
      input  rq1_read_rq, rq1_write_rq, rq1_address, rq1_write_data,
      output rq1_read_data, rq1_finished,
      output ext_read_rq, ext_write_rq, ext_address, ext_write_data,
      input  ext_rq_finished, ext_read_data,
      output grant, busy
   );

   modport master (
      output rq0_read_rq, rq0_write_rq, rq0_address, rq0_write_data,
      input  rq0_read_data, rq0_finished,
      output rq1_read_rq, rq1_write_rq, rq1_address, rq1_write_data,
      input  rq1_read_data, rq1_finished,
      input  ext_read_rq, ext_write_rq, ext_address, ext_write_data,
      output ext_rq_finished, ext_read_data,
      input  grant, busy
   );

endinterface

// File: rtl/ddr3_line_arbiter.sv
// ddr3_line_arbiter
// Shares one DDR3 line interface between two line-granular requesters.
// One transaction at a time: IDLE picks a winner and latches its request,
// WAIT holds the controller request until completion, DONE pulses the
// winner's finished flag. Every output is a register.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined     -> contested grants alternate between the ports
//   not defined -> port 0 always wins a tie
module ddr3_line_arbiter #(
   parameter int LINES_W    = 128,
   parameter int EXT_ADDR_W = 26
) (
   input logic               clk,
   input logic               reset,
   ddr3_line_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic                  owner;
   logic                  op_write;

   logic                  req0;
   logic                  req1;
   logic                  win;
   logic                  win_write;
   logic [EXT_ADDR_W-1:0] win_addr;
   logic [LINES_W-1:0]    win_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic                  last_grant;

   // Winner choice: a tie goes to the port that was not granted last time.
   always_comb begin
      req0 = bus.rq0_read_rq | bus.rq0_write_rq;
      req1 = bus.rq1_read_rq | bus.rq1_write_rq;
      win  = 1'b0;
      if (req0 && req1) begin
         win = ~last_grant;
      end else if (req1) begin
         win = 1'b1;
      end
   end

   // Last-grant pointer, moved on every grant; starts at port 1 so the
   // first contested grant after reset goes to port 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (state == IDLE && (req0 || req1)) begin
         last_grant <= win;
      end
   end
`else
   // Winner choice: fixed priority, port 0 wins whenever it is requesting.
   always_comb begin
      req0 = bus.rq0_read_rq | bus.rq0_write_rq;
      req1 = bus.rq1_read_rq | bus.rq1_write_rq;
      win  = 1'b0;
      if (!req0 && req1) begin
         win = 1'b1;
      end
   end
`endif

   // Request fields of the chosen port; a write beats a read when both are up.
   always_comb begin
      win_addr  = bus.rq0_address;
      win_data  = bus.rq0_write_data;
      win_write = bus.rq0_write_rq;
      if (win) begin
         win_addr  = bus.rq1_address;
         win_data  = bus.rq1_write_data;
         win_write = bus.rq1_write_rq;
      end
   end

   // Transaction FSM with every interface output registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         owner              <= 1'b0;
         op_write           <= 1'b0;
         bus.ext_read_rq    <= 1'b0;
         bus.ext_write_rq   <= 1'b0;
         bus.ext_address    <= {EXT_ADDR_W{1'b0}};
         bus.ext_write_data <= {LINES_W{1'b0}};
         bus.rq0_read_data  <= {LINES_W{1'b0}};
         bus.rq1_read_data  <= {LINES_W{1'b0}};
         bus.rq0_finished   <= 1'b0;
         bus.rq1_finished   <= 1'b0;
         bus.grant          <= 2'b00;
         bus.busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.rq0_finished <= 1'b0;
               bus.rq1_finished <= 1'b0;
               if (req0 || req1) begin
                  owner              <= win;
                  op_write           <= win_write;
                  bus.ext_address    <= win_addr;
                  bus.ext_write_data <= win_data;
                  bus.ext_write_rq   <= win_write;
                  bus.ext_read_rq    <= ~win_write;
                  bus.grant          <= win ? 2'b10 : 2'b01;
                  bus.busy           <= 1'b1;
                  state              <= WAIT;
               end
            end

            WAIT: begin
               if (bus.ext_rq_finished) begin
                  bus.ext_read_rq  <= 1'b0;
                  bus.ext_write_rq <= 1'b0;
                  if (!op_write) begin
                     if (owner) begin
                        bus.rq1_read_data <= bus.ext_read_data;
                     end else begin
                        bus.rq0_read_data <= bus.ext_read_data;
                     end
                  end
                  bus.rq0_finished <= ~owner;
                  bus.rq1_finished <= owner;
                  state            <= DONE;
               end
            end

            DONE: begin
               bus.rq0_finished <= 1'b0;
               bus.rq1_finished <= 1'b0;
               bus.grant        <= 2'b00;
               bus.busy         <= 1'b0;
               state            <= IDLE;
            end

            default: begin
               bus.ext_read_rq  <= 1'b0;
               bus.ext_write_rq <= 1'b0;
               bus.rq0_finished <= 1'b0;
               bus.rq1_finished <= 1'b0;
               bus.grant        <= 2'b00;
               bus.busy         <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_line_arbiter.sv
// tb_ddr3_line_arbiter
// Directed, table-driven bench for ddr3_line_arbiter. Each table row gives the
// inputs applied for one cycle and the outputs expected right after that edge.
// Build with +define+ARB_ROUND_ROBIN_EN to exercise the round-robin variant.
module tb_ddr3_line_arbiter;

   localparam int LW = 128;
   localparam int AW = 26;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam logic [LW-1:0] LINE_A = {4{32'hDEADBEEF}};
   localparam logic [LW-1:0] LINE_B = {4{32'h01234567}};
   localparam logic [LW-1:0] LINE_C = {2{64'hCAFEF00D_5A5A5A5A}};
   localparam logic [LW-1:0] WDAT0  = {4{32'h11112222}};
   localparam logic [LW-1:0] WDAT1  = {LW{1'b1}};
   localparam logic [AW-1:0] ADDR0  = 26'h0000123;
   localparam logic [AW-1:0] ADDR1  = 26'h3FFFFFF;

   typedef struct {
      logic [5:0]    in_bits;
      logic [LW-1:0] xrd;
      logic [6:0]    e_ctrl;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wdata;
      logic [LW-1:0] e_rd0;
      logic [LW-1:0] e_rd1;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   vec_t          vecs[$];
   logic [AW-1:0] ea;
   logic [LW-1:0] ew;
   logic [LW-1:0] e0;
   logic [LW-1:0] e1;

   ddr3_line_arbiter_if #(.LINES_W(LW), .EXT_ADDR_W(AW)) bus ();

   ddr3_line_arbiter #(.LINES_W(LW), .EXT_ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Appends one row, taking the latched-value expectations from ea/ew/e0/e1.
   task automatic addVec(input logic [5:0] in_bits, input logic [LW-1:0] xrd,
                         input logic [6:0] e_ctrl);
      vec_t v;
      v.in_bits = in_bits;
      v.xrd     = xrd;
      v.e_ctrl  = e_ctrl;
      v.e_addr  = ea;
      v.e_wdata = ew;
      v.e_rd0   = e0;
      v.e_rd1   = e1;
      vecs.push_back(v);
   endtask

   // in_bits = {reset, rq0_rd, rq0_wr, rq1_rd, rq1_wr, ext_fin}
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset               = v.in_bits[5];
      bus.rq0_read_rq     = v.in_bits[4];
      bus.rq0_write_rq    = v.in_bits[3];
      bus.rq1_read_rq     = v.in_bits[2];
      bus.rq1_write_rq    = v.in_bits[1];
      bus.ext_rq_finished = v.in_bits[0];
      bus.ext_read_data   = v.xrd;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string name, input int row,
                           input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL row%0d %s: got %h expected %h", row, name, got, exp);
      end
   endtask

   // e_ctrl = {grant[1:0], ext_read_rq, ext_write_rq, rq0_finished, rq1_finished, busy}
   task automatic checkOutput(input int row, input vec_t v);
      logic [6:0] ctrl;
      ctrl = {bus.grant, bus.ext_read_rq, bus.ext_write_rq,
              bus.rq0_finished, bus.rq1_finished, bus.busy};
      checkVal("ctrl", row, {{(LW-7){1'b0}}, ctrl}, {{(LW-7){1'b0}}, v.e_ctrl});
      checkVal("ext_address", row, {{(LW-AW){1'b0}}, bus.ext_address},
               {{(LW-AW){1'b0}}, v.e_addr});
      checkVal("ext_write_data", row, bus.ext_write_data, v.e_wdata);
      checkVal("rq0_read_data", row, bus.rq0_read_data, v.e_rd0);
      checkVal("rq1_read_data", row, bus.rq1_read_data, v.e_rd1);
   endtask

   // Builds the directed table and runs it, then the hand-written latency case.
   initial begin
      logic       p;
      logic [1:0] g;
      int         n;

      checks              = 0;
      failures            = 0;
      reset               = 1'b1;
      bus.rq0_read_rq     = 1'b0;
      bus.rq0_write_rq    = 1'b0;
      bus.rq1_read_rq     = 1'b0;
      bus.rq1_write_rq    = 1'b0;
      bus.rq0_address     = ADDR0;
      bus.rq1_address     = ADDR1;
      bus.rq0_write_data  = WDAT0;
      bus.rq1_write_data  = WDAT1;
      bus.ext_rq_finished = 1'b0;
      bus.ext_read_data   = '0;

      ea = '0; ew = '0; e0 = '0; e1 = '0;

      // Reset, then a spurious completion in IDLE.
      addVec(6'b1_0000_0, LINE_A, 7'b00_0_0_0_0_0);
      addVec(6'b0_0000_1, LINE_A, 7'b00_0_0_0_0_0);

      // Port 0 read, controller answers in the fifth WAIT cycle.
      ea = ADDR0; ew = WDAT0;
      addVec(6'b0_1000_0, LINE_A, 7'b01_1_0_0_0_1);
      for (int i = 0; i < 4; i++) addVec(6'b0_1000_0, LINE_A, 7'b01_1_0_0_0_1);
      e0 = LINE_A;
      addVec(6'b0_1000_1, LINE_A, 7'b01_0_0_1_0_1);
      addVec(6'b0_1000_0, LINE_B, 7'b00_0_0_0_0_0);
      addVec(6'b0_0000_0, LINE_B, 7'b00_0_0_0_0_0);

      // Port 1 write at the top address with all-ones data.
      ea = ADDR1; ew = WDAT1;
      addVec(6'b0_0001_0, LINE_B, 7'b10_0_1_0_0_1);
      addVec(6'b0_0001_1, LINE_B, 7'b10_0_0_0_1_1);
      addVec(6'b0_0001_0, LINE_B, 7'b00_0_0_0_0_0);
      addVec(6'b0_0000_0, LINE_B, 7'b00_0_0_0_0_0);

      // Port 0 read+write together: write first, then the read.
      ea = ADDR0; ew = WDAT0;
      addVec(6'b0_1100_0, LINE_B, 7'b01_0_1_0_0_1);
      addVec(6'b0_1100_1, LINE_B, 7'b01_0_0_1_0_1);
      addVec(6'b0_1100_0, LINE_B, 7'b00_0_0_0_0_0);
      addVec(6'b0_1000_0, LINE_B, 7'b01_1_0_0_0_1);
      e0 = LINE_B;
      addVec(6'b0_1000_1, LINE_B, 7'b01_0_0_1_0_1);
      addVec(6'b0_1000_0, LINE_C, 7'b00_0_0_0_0_0);
      addVec(6'b0_0000_0, LINE_C, 7'b00_0_0_0_0_0);

      // Reset during WAIT, late completion afterwards is ignored.
      ea = ADDR1; ew = WDAT1;
      addVec(6'b0_0010_0, LINE_C, 7'b10_1_0_0_0_1);
      ea = '0; ew = '0; e0 = '0; e1 = '0;
      addVec(6'b1_0010_0, LINE_C, 7'b00_0_0_0_0_0);
      addVec(6'b0_0000_1, LINE_C, 7'b00_0_0_0_0_0);
      addVec(6'b0_0000_0, LINE_C, 7'b00_0_0_0_0_0);

      // Both ports read continuously, controller finishes at once.
      for (int k = 0; k < 4; k++) begin
         p  = RR ? k[0] : 1'b0;
         g  = p ? 2'b10 : 2'b01;
         ea = p ? ADDR1 : ADDR0;
         ew = p ? WDAT1 : WDAT0;
         addVec(6'b0_1010_1, LINE_C, {g, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
         if (p) e1 = LINE_C;
         else   e0 = LINE_C;
         addVec(6'b0_1010_1, LINE_C, {g, 1'b0, 1'b0, ~p, p, 1'b1});
         addVec(6'b0_1010_1, LINE_C, 7'b00_0_0_0_0_0);
      end
      addVec(6'b0_0000_0, LINE_C, 7'b00_0_0_0_0_0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end

      // Port 0 write, completion held back two WAIT cycles; rq0_finished must
      // appear four edges after the request and last exactly one cycle.
      @(negedge clk);
      bus.rq0_address      = 26'h0ABCDEF;
      bus.rq0_write_rq     = 1'b1;
      bus.ext_rq_finished  = 1'b0;
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            checks++;
            if (bus.ext_write_rq !== 1'b1 || bus.ext_address !== 26'h0ABCDEF) begin
               failures++;
               $display("[TB] FAIL seq_write_issue: got wr=%b addr=%h expected wr=1 addr=0abcdef",
                        bus.ext_write_rq, bus.ext_address);
            end
         end
         if (bus.rq0_finished === 1'b1) begin
            n = c;
            break;
         end
         bus.ext_rq_finished = (c == 3);
      end
      bus.ext_rq_finished = 1'b0;
      checks++;
      if (n != 4) begin
         failures++;
         $display("[TB] FAIL seq_latency: got %0d edges expected 4 (0 = timeout)", n);
      end
      @(posedge clk);
      #1;
      bus.rq0_write_rq = 1'b0;
      checks++;
      if (bus.rq0_finished !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
         failures++;
         $display("[TB] FAIL seq_pulse_end: got fin=%b busy=%b grant=%b expected 0 0 00",
                  bus.rq0_finished, bus.busy, bus.grant);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.ext_write_rq !== 1'b0) begin
         failures++;
         $display("[TB] FAIL seq_no_regrant: got busy=%b wr=%b expected 0 0",
                  bus.busy, bus.ext_write_rq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
